db_event_sched: RTL

Multi-channel debounce controller and event scheduler for the switch-input path. It shares one sample prescaler across `NUM_CH` switch inputs and runs a debounce state machine per channel. Debounced rising edges are queued as pending events and serialised onto a single valid/ready event port by a round-robin arbiter. It sits between the raw board switches and the control logic that consumes button presses.

---
 rtl/db_event_sched.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/db_event_sched.sv
// db_event_sched: multi-channel switch debounce with a round-robin event port.
// One shared prescaler produces a sample strobe every SAMPLE_DIV cycles. Each
// channel runs a four-state debounce FSM on that strobe. A debounced rising
// edge sets the channel's pending bit. A round-robin arbiter serialises the
// pending bits onto a single valid/ready event port.
// Optional feature: define DB_EVENT_SCHED_SYNC_EN to add a two-flop input
// synchronizer per channel. This adds 2 cycles to every debounce latency.
module db_event_sched #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 1000,
    parameter int DB_SAMPLES = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_CH-1:0]         sw_i,
    output logic [NUM_CH-1:0]         db_level_o,
    output logic [NUM_CH-1:0]         db_tick_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(NUM_CH)-1:0] evt_id_o,
    output logic [NUM_CH-1:0]         evt_overrun_o
);

    localparam int IDW  = $clog2(NUM_CH);
    localparam int CNTW = $clog2(DB_SAMPLES + 1);
    localparam int PW   = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_e;

    logic [PW-1:0]     presc_r;
    logic              sample_stb_s;
    logic [NUM_CH-1:0] sw_s;
    state_e            state_r    [NUM_CH];
    state_e            state_nx_s [NUM_CH];
    logic [CNTW-1:0]   cnt_r      [NUM_CH];
    logic [CNTW-1:0]   cnt_nx_s   [NUM_CH];
    logic [NUM_CH-1:0] level_nx_s;
    logic [NUM_CH-1:0] tick_nx_s;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] hs_mask_s;
    logic [NUM_CH-1:0] avail_s;
    logic              hs_s;
    logic              found_s;
    logic [IDW-1:0]    base_s;
    logic [IDW-1:0]    sel_s;
    logic [IDW-1:0]    idx_s;
    logic [IDW-1:0]    last_grant_r;

    assign sample_stb_s = (presc_r == PW'(SAMPLE_DIV - 1));
    assign hs_s         = evt_valid_o & evt_ready_i;

`ifdef DB_EVENT_SCHED_SYNC_EN
    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] sync2_r;

    // Two-flop synchronizer in front of the debounce FSMs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sw_i;
            sync2_r <= sync1_r;
        end
    end

    assign sw_s = sync2_r;
`else
    assign sw_s = sw_i;
`endif

    // Shared prescaler: counts 0..SAMPLE_DIV-1 and wraps on the strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_r <= '0;
        end else if (sample_stb_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Per-channel debounce next state. The FSMs only move on the sample strobe.
    always_comb begin
        level_nx_s = db_level_o;
        tick_nx_s  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_nx_s[ch] = state_r[ch];
            cnt_nx_s[ch]   = cnt_r[ch];
            if (sample_stb_s) begin
                case (state_r[ch])
                    ST_ZERO: begin
                        if (sw_s[ch]) begin
                            state_nx_s[ch] = ST_WAIT1;
                            cnt_nx_s[ch]   = CNTW'(1);
                        end else begin
                            state_nx_s[ch] = ST_ZERO;
                        end
                    end
                    ST_WAIT1: begin
                        if (!sw_s[ch]) begin
                            state_nx_s[ch] = ST_ZERO;
                        end else if (cnt_r[ch] == CNTW'(DB_SAMPLES - 1)) begin
                            state_nx_s[ch] = ST_ONE;
                            level_nx_s[ch] = 1'b1;
                            tick_nx_s[ch]  = 1'b1;
                        end else begin
                            cnt_nx_s[ch] = cnt_r[ch] + CNTW'(1);
                        end
                    end
                    ST_ONE: begin
                        if (!sw_s[ch]) begin
                            state_nx_s[ch] = ST_WAIT0;
                            cnt_nx_s[ch]   = CNTW'(1);
                        end else begin
                            state_nx_s[ch] = ST_ONE;
                        end
                    end
                    ST_WAIT0: begin
                        if (sw_s[ch]) begin
                            state_nx_s[ch] = ST_ONE;
                        end else if (cnt_r[ch] == CNTW'(DB_SAMPLES - 1)) begin
                            state_nx_s[ch] = ST_ZERO;
                            level_nx_s[ch] = 1'b0;
                        end else begin
                            cnt_nx_s[ch] = cnt_r[ch] + CNTW'(1);
                        end
                    end
                    default: begin
                        state_nx_s[ch] = ST_ZERO;
                        cnt_nx_s[ch]   = '0;
                        level_nx_s[ch] = 1'b0;
                    end
                endcase
            end else begin
                state_nx_s[ch] = state_r[ch];
            end
        end
    end

    // Debounce state, debounced level and the registered tick pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_r[ch] <= ST_ZERO;
                cnt_r[ch]   <= '0;
            end
            db_level_o <= '0;
            db_tick_o  <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_r[ch] <= state_nx_s[ch];
                cnt_r[ch]   <= cnt_nx_s[ch];
            end
            db_level_o <= level_nx_s;
            db_tick_o  <= tick_nx_s;
        end
    end

    // Round-robin pick. The channel being accepted this cycle is excluded
    // because its pending bit clears on this same edge.
    always_comb begin
        hs_mask_s = '0;
        if (hs_s) begin
            hs_mask_s[evt_id_o] = 1'b1;
        end else begin
            hs_mask_s = '0;
        end
        avail_s = pending_r & ~hs_mask_s;
        base_s  = hs_s ? evt_id_o : last_grant_r;
        found_s = 1'b0;
        sel_s   = '0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s = IDW'((int'(base_s) + i) % NUM_CH);
            if (!found_s && avail_s[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
                sel_s   = sel_s;
            end
        end
    end

    // Pending bits and sticky overrun flags. A tick landing on a handshake
    // of the same channel starts a fresh event rather than flagging overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r     <= '0;
            evt_overrun_o <= '0;
        end else begin
            pending_r     <= tick_nx_s | (pending_r & ~hs_mask_s);
            evt_overrun_o <= evt_overrun_o | (tick_nx_s & pending_r & ~hs_mask_s);
        end
    end

    // Event port registers. The offer is held stable while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_valid_o  <= 1'b0;
            evt_id_o     <= '0;
            last_grant_r <= IDW'(NUM_CH - 1);
        end else begin
            if (hs_s) begin
                last_grant_r <= evt_id_o;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if (!evt_valid_o || hs_s) begin
                evt_valid_o <= found_s;
                if (found_s) begin
                    evt_id_o <= sel_s;
                end else begin
                    evt_id_o <= evt_id_o;
                end
            end else begin
                evt_valid_o <= evt_valid_o;
                evt_id_o    <= evt_id_o;
            end
        end
    end

endmodule
